// File: rtl/fixture_loopback_checker.sv
// Loopback traffic source/sink for the fixture: drives an LFSR pattern, checks the
// looped-back bus against a delayed copy and checks the fixture cycle count steps by one.
module fixture_loopback_checker #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned LATENCY   = 0,
  parameter int unsigned NUM_WORDS = 256,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] pattern_out,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [7:0]       count_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             count_err,
  output logic [15:0]      first_err_index,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [15:0] LastIdx   = 16'(NUM_WORDS - 1);
  localparam logic [2:0]  LastDrain = 3'((LATENCY == 0) ? 0 : LATENCY - 1);

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // State replicated across the bus, then truncated to WIDTH.
  function automatic logic [WIDTH-1:0] to_word(input logic [31:0] s);
    logic [95:0] rep;
    rep = {3{s}};
    return rep[WIDTH-1:0];
  endfunction

  logic [1:0]       r_state, w_state_d;
  logic [31:0]      r_lfsr;
  logic [WIDTH-1:0] r_pattern;
  logic [15:0]      r_idx;
  logic [2:0]       r_drain_cnt;
  logic [ERR_W-1:0] r_err_cnt, w_err_next;
  logic             r_count_err, w_count_err_next;
  logic             r_have_err;
  logic [15:0]      r_first_idx;
  logic [WIDTH-1:0] r_first_exp, r_first_act;
  logic             r_pass;
  logic [7:0]       r_prev_count;
  logic             r_prev_valid;

  logic             w_busy, w_start_run, w_issue_valid, w_enter_done;
  logic             w_exp_valid, w_mismatch, w_count_viol;
  logic [WIDTH-1:0] w_exp_word;
  logic [15:0]      w_exp_idx;
  logic [7:0]       w_count_exp;

  assign w_busy        = (r_state == StRun) || (r_state == StDrain);
  assign w_start_run   = ((r_state == StIdle) || (r_state == StDone)) && start;
  assign w_issue_valid = (r_state == StRun);

  // Expected-word delay line: word and index travel with a valid bit.
  generate
    if (LATENCY == 0) begin : g_nodl
      assign w_exp_valid = w_issue_valid;
      assign w_exp_word  = r_pattern;
      assign w_exp_idx   = r_idx;
    end else begin : g_dl
      logic [LATENCY-1:0] r_dl_valid;
      logic [WIDTH-1:0]   r_dl_word [LATENCY];
      logic [15:0]        r_dl_idx  [LATENCY];

      // Valid bits: cleared by reset and by every run start so stale words never compare.
      always_ff @(posedge clk) begin
        if (!sync_rst_n || w_start_run) begin
          r_dl_valid <= '0;
        end else begin
          r_dl_valid[0] <= w_issue_valid;
          for (int i = 1; i < int'(LATENCY); i++) r_dl_valid[i] <= r_dl_valid[i-1];
        end
      end

      // Payload shift; qualified by the valid bits so no reset needed.
      always_ff @(posedge clk) begin
        r_dl_word[0] <= r_pattern;
        r_dl_idx[0]  <= r_idx;
        for (int i = 1; i < int'(LATENCY); i++) begin
          r_dl_word[i] <= r_dl_word[i-1];
          r_dl_idx[i]  <= r_dl_idx[i-1];
        end
      end

      assign w_exp_valid = r_dl_valid[LATENCY-1];
      assign w_exp_word  = r_dl_word[LATENCY-1];
      assign w_exp_idx   = r_dl_idx[LATENCY-1];
    end
  endgenerate

  // Compare and count checks for the current cycle, plus the values they lead to.
  always_comb begin
    w_mismatch       = w_busy && w_exp_valid && (pattern_in != w_exp_word);
    w_err_next       = r_err_cnt;
    if (w_mismatch && !(&r_err_cnt)) w_err_next = r_err_cnt + 1'b1;
    w_count_exp      = r_prev_count + 8'd1;
    w_count_viol     = w_busy && r_prev_valid && (count_in != w_count_exp);
    w_count_err_next = r_count_err || w_count_viol;
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StRun;
      StRun: begin
        if (stop) w_state_d = StDone;
        else if (r_idx == LastIdx) w_state_d = (LATENCY > 0) ? StDrain : StDone;
      end
      StDrain: begin
        if (stop || (r_drain_cnt == LastDrain)) w_state_d = StDone;
      end
      StDone:  if (start) w_state_d = StRun;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_enter_done = w_busy && (w_state_d == StDone);

  // Main state: FSM, pattern generator, error bookkeeping and pass flag.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_state      <= StIdle;
      r_lfsr       <= SEED;
      r_pattern    <= '0;
      r_idx        <= '0;
      r_drain_cnt  <= '0;
      r_err_cnt    <= '0;
      r_count_err  <= 1'b0;
      r_have_err   <= 1'b0;
      r_first_idx  <= '0;
      r_first_exp  <= '0;
      r_first_act  <= '0;
      r_pass       <= 1'b0;
      r_prev_count <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_start_run) begin
        // Word 0 comes straight from SEED; r_lfsr then holds the state for word 1.
        r_pattern    <= to_word(SEED);
        r_lfsr       <= lfsr_adv(SEED);
        r_idx        <= '0;
        r_drain_cnt  <= '0;
        r_err_cnt    <= '0;
        r_count_err  <= 1'b0;
        r_have_err   <= 1'b0;
        r_first_idx  <= '0;
        r_first_exp  <= '0;
        r_first_act  <= '0;
        r_pass       <= 1'b0;
        r_prev_valid <= 1'b0;
      end else begin
        if ((r_state == StRun) && (w_state_d == StRun)) begin
          r_pattern <= to_word(r_lfsr);
          r_lfsr    <= lfsr_adv(r_lfsr);
          r_idx     <= r_idx + 16'd1;
        end
        if (r_state == StDrain) r_drain_cnt <= r_drain_cnt + 3'd1;
        if (w_busy) begin
          r_err_cnt    <= w_err_next;
          r_count_err  <= w_count_err_next;
          r_prev_count <= count_in;
          r_prev_valid <= 1'b1;
          if (w_mismatch && !r_have_err) begin
            r_have_err  <= 1'b1;
            r_first_idx <= w_exp_idx;
            r_first_exp <= w_exp_word;
            r_first_act <= pattern_in;
          end
        end else begin
          r_prev_valid <= 1'b0;
        end
        // Includes this cycle's compare so the final word counts toward pass.
        if (w_enter_done) r_pass <= (w_err_next == '0) && !w_count_err_next && !stop;
      end
    end
  end

  assign pattern_out     = r_pattern;
  assign busy            = w_busy;
  assign done            = (r_state == StDone);
  assign pass            = r_pass;
  assign err_count       = r_err_cnt;
  assign count_err       = r_count_err;
  assign first_err_index = r_first_idx;
  assign first_err_exp   = r_first_exp;
  assign first_err_act   = r_first_act;

endmodule
